// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-channel, W-bit stream multiplexer with valid/ready on every
// channel. Arbitration is round-robin (mode=0) or forced select (mode=1). The
// winner goes into a single registered output stage.
// Optional feature macro: PKT_LOCK_EN adds in_last/out_last. It also holds the
// grant on one channel until that channel sends a beat with in_last set.

module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  input  logic [N_CH*W-1:0]   in_data,
`ifdef PKT_LOCK_EN
  input  logic [N_CH-1:0]     in_last,
  output logic                out_last,
`endif
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic [SELW-1:0]     out_chan
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic            ld;
  logic            accept;
  logic            sel_ok;
  logic            lock;
  logic [SELW-1:0] lk_ch;

  // Channel index base+k, wrapped modulo N_CH.
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CH) s = s - N_CH;
    return s[SELW-1:0];
  endfunction

  // A sel value outside the channel range must never produce a grant.
  assign sel_ok = (int'(sel) < N_CH);

  // The output register can take a new beat when it is empty or being drained.
  assign ld = !out_valid || out_ready;

  // Choose the winning channel from the current inputs: lock first, then mode.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (lock) begin
      grant     = lk_ch;
      grant_vld = in_valid[lk_ch];
    end else if (!mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!grant_vld && in_valid[wrap_idx(rr_ptr, k)]) begin
          grant_vld = 1'b1;
          grant     = wrap_idx(rr_ptr, k);
        end
      end
    end else if (sel_ok && in_valid[sel]) begin
      grant_vld = 1'b1;
      grant     = sel;
    end
  end

  // Ready is gated by reset so that no channel sees a handshake while reset is held.
  assign accept = rst_n && ld && grant_vld;

  // One-hot ready for the granted channel only.
  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // Output register: load on accept, clear valid on a drain with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*W +: W];
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves one past the winner on every mode-0 accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && !mode) begin
      rr_ptr <= (grant == SELW'(N_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

`ifdef PKT_LOCK_EN
  // Packet lock: a non-last beat pins the grant to its channel; a last beat releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lk_ch    <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      lock     <= !in_last[grant];
      lk_ch    <= grant;
      out_last <= in_last[grant];
    end
  end
`else
  assign lock  = 1'b0;
  assign lk_ch = '0;
`endif

endmodule
